// File: rtl/spike_motor_decoder_if.sv
// -----------------------------------------------------------------------------
// spike_motor_decoder_if
//
// Signal bundle between the spiking network and the spike rate decoder / PWM
// motor driver.
//
//   master : network side. Drives en and spike_in, observes the motor outputs.
//   slave  : decoder side. Consumes en and spike_in, drives the motor outputs.
//
// Signals
//   en          global enable shared with the network
//   spike_in    [0] = Left output neuron, [1] = Right output neuron
//   duty_l/r    shadow duty cycles written once per counting window
//   pwm_l/r     motor PWM outputs
//   turn_cmd    00 straight, 01 left, 10 right
//   window_done one-cycle pulse when duty_l, duty_r and turn_cmd update
// -----------------------------------------------------------------------------
interface spike_motor_decoder_if #(
    parameter int PWM_W = 8
) ();
    logic             en;
    logic [1:0]       spike_in;
    logic [PWM_W-1:0] duty_l;
    logic [PWM_W-1:0] duty_r;
    logic             pwm_l;
    logic             pwm_r;
    logic [1:0]       turn_cmd;
    logic             window_done;

    modport master (
        output en,
        output spike_in,
        input  duty_l,
        input  duty_r,
        input  pwm_l,
        input  pwm_r,
        input  turn_cmd,
        input  window_done
    );

    modport slave (
        input  en,
        input  spike_in,
        output duty_l,
        output duty_r,
        output pwm_l,
        output pwm_r,
        output turn_cmd,
        output window_done
    );
endinterface

// File: rtl/spike_motor_decoder.sv
// -----------------------------------------------------------------------------
// spike_motor_decoder
//
// Counts Left/Right output spikes over a window of WINDOW enabled cycles. It
// turns the rate difference into differential motor duties around BASE_DUTY and
// drives two PWM outputs. Those outputs only pick up a new duty at a PWM period
// boundary, so a period is never cut short or stretched by an update.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous, active-low reset; clears every register
//   bus.slave  en, spike_in in; duty_l, duty_r, pwm_l, pwm_r, turn_cmd,
//              window_done out (see spike_motor_decoder_if)
//
// Flow
//   COUNT : window counter and spike counters run while en=1. At end of window
//           the closing counts (including that cycle's spikes) are latched as
//           rates and the counters restart from zero.
//   CALC  : one enabled cycle later the duties and turn command are computed
//           from the latched rates and written. window_done pulses with them.
//   Spike counting keeps running in CALC; CALC only reads the latched rates.
// -----------------------------------------------------------------------------
module spike_motor_decoder #(
    parameter int WINDOW    = 1024,
    parameter int CNT_W     = 10,
    parameter int PWM_W     = 8,
    parameter int BASE_DUTY = 128,
    parameter int SHIFT     = 2,
    parameter int DEADBAND  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    spike_motor_decoder_if.slave bus
);

    localparam int WC_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    // Rate difference scaled by the gain, with headroom for the sign and shift.
    localparam int DW   = CNT_W + SHIFT + 2;
    // Duty sum width: must hold BASE_DUTY +/- the scaled difference without wrap.
    localparam int SW   = ((DW > PWM_W + 1) ? DW : PWM_W + 1) + 1;

    localparam logic [WC_W-1:0]      WC_LAST    = WC_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0]     CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [PWM_W-1:0]     PCNT_LAST  = {PWM_W{1'b1}};
    localparam logic signed [SW-1:0] BASE_S     = SW'(BASE_DUTY);
    localparam logic signed [SW-1:0] DUTY_MAX_S = SW'((1 << PWM_W) - 1);
    localparam logic signed [DW-1:0] DB_S       = DW'(DEADBAND);

    typedef enum logic [0:0] {
        S_COUNT = 1'b0,
        S_CALC  = 1'b1
    } state_t;

    // Saturating increment of a spike counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                                 input logic             inc);
        logic [CNT_W-1:0] r;
        r = c;
        if (inc && (c != CNT_MAX)) begin
            r = c + CNT_W'(1);
        end
        return r;
    endfunction

    // Clamp a signed duty sum into 0 .. 2^PWM_W-1.
    function automatic logic [PWM_W-1:0] clamp_duty(input logic signed [SW-1:0] v);
        logic [PWM_W-1:0] r;
        if (v[SW-1]) begin
            r = '0;
        end else if (v > DUTY_MAX_S) begin
            r = '1;
        end else begin
            r = v[PWM_W-1:0];
        end
        return r;
    endfunction

    // Turn command from diff_rl = rate_r - rate_l; inside the deadband is straight.
    function automatic logic [1:0] turn_of(input logic signed [DW-1:0] diff_rl);
        logic [1:0] r;
        if (-diff_rl >= DB_S) begin
            r = 2'b01;
        end else if (diff_rl >= DB_S) begin
            r = 2'b10;
        end else begin
            r = 2'b00;
        end
        return r;
    endfunction

    state_t           state;
    logic [WC_W-1:0]  wcnt_p0;
    logic [CNT_W-1:0] cnt_l_p0;
    logic [CNT_W-1:0] cnt_r_p0;
    logic [CNT_W-1:0] rate_l_p1;
    logic [CNT_W-1:0] rate_r_p1;
    logic [PWM_W-1:0] duty_l_p2;
    logic [PWM_W-1:0] duty_r_p2;
    logic [1:0]       turn_p2;
    logic             vld_p2;
    logic [PWM_W-1:0] pcnt;
    logic [PWM_W-1:0] act_l;
    logic [PWM_W-1:0] act_r;
    logic             pwm_l_q;
    logic             pwm_r_q;

    logic                 eow;
    logic                 calc_go;
    logic signed [DW-1:0] rate_l_s;
    logic signed [DW-1:0] rate_r_s;
    logic signed [DW-1:0] diff_rl;
    logic signed [DW-1:0] d;
    logic signed [SW-1:0] d_ext;
    logic signed [SW-1:0] sum_l;
    logic signed [SW-1:0] sum_r;
    logic [PWM_W-1:0]     duty_l_nxt;
    logic [PWM_W-1:0]     duty_r_nxt;

    assign eow     = bus.en && (wcnt_p0 == WC_LAST);
    assign calc_go = bus.en && (state == S_CALC);

    assign rate_l_s = $signed({{(DW - CNT_W){1'b0}}, rate_l_p1});
    assign rate_r_s = $signed({{(DW - CNT_W){1'b0}}, rate_r_p1});
    assign diff_rl  = rate_r_s - rate_l_s;
    assign d        = diff_rl <<< SHIFT;
    assign d_ext    = {{(SW - DW){d[DW-1]}}, d};
    assign sum_l    = BASE_S + d_ext;
    assign sum_r    = BASE_S - d_ext;

    // Next shadow duty. The PWM reload below uses this value too, so a write
    // landing on the period-end cycle is taken by the very next period.
    always_comb begin
        duty_l_nxt = duty_l_p2;
        duty_r_nxt = duty_r_p2;
        if (calc_go) begin
            duty_l_nxt = clamp_duty(sum_l);
            duty_r_nxt = clamp_duty(sum_r);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_COUNT;
            wcnt_p0   <= '0;
            cnt_l_p0  <= '0;
            cnt_r_p0  <= '0;
            rate_l_p1 <= '0;
            rate_r_p1 <= '0;
            duty_l_p2 <= '0;
            duty_r_p2 <= '0;
            turn_p2   <= 2'b00;
            vld_p2    <= 1'b0;
            pcnt      <= '0;
            act_l     <= '0;
            act_r     <= '0;
            pwm_l_q   <= 1'b0;
            pwm_r_q   <= 1'b0;
        end else begin
            vld_p2 <= 1'b0;
            if (bus.en) begin
                pcnt <= pcnt + PWM_W'(1);

                // p0 -> p1: window count, spike count, rate latch at end of window
                if (eow) begin
                    wcnt_p0   <= '0;
                    cnt_l_p0  <= '0;
                    cnt_r_p0  <= '0;
                    rate_l_p1 <= sat_inc(cnt_l_p0, bus.spike_in[0]);
                    rate_r_p1 <= sat_inc(cnt_r_p0, bus.spike_in[1]);
                end else begin
                    wcnt_p0  <= wcnt_p0 + WC_W'(1);
                    cnt_l_p0 <= sat_inc(cnt_l_p0, bus.spike_in[0]);
                    cnt_r_p0 <= sat_inc(cnt_r_p0, bus.spike_in[1]);
                end

                // p1 -> p2: duty / turn computation in CALC
                case (state)
                    S_COUNT: begin
                        if (eow) begin
                            state <= S_CALC;
                        end
                    end
                    S_CALC: begin
                        state   <= S_COUNT;
                        vld_p2  <= 1'b1;
                        turn_p2 <= turn_of(diff_rl);
                    end
                    default: state <= S_COUNT;
                endcase
            end

            duty_l_p2 <= duty_l_nxt;
            duty_r_p2 <= duty_r_nxt;

            // p2 -> PWM: active duty reloads only at the last count of a period
            if (pcnt == PCNT_LAST) begin
                act_l <= duty_l_nxt;
                act_r <= duty_r_nxt;
            end
            pwm_l_q <= bus.en && (pcnt < act_l);
            pwm_r_q <= bus.en && (pcnt < act_r);
        end
    end

    assign bus.duty_l      = duty_l_p2;
    assign bus.duty_r      = duty_r_p2;
    assign bus.turn_cmd    = turn_p2;
    assign bus.window_done = vld_p2;
    assign bus.pwm_l       = pwm_l_q;
    assign bus.pwm_r       = pwm_r_q;

endmodule

// File: doc/spike_motor_decoder.md
# spike_motor_decoder

Rate decoder and PWM motor driver that sits directly downstream of the spiking network's two excitatory output neurons (Left = bit 0, Right = bit 1). It counts output spikes over a fixed window and converts the left/right rate difference into differential duty cycles. It then drives two glitch-free PWM outputs for the robot's left and right motors, plus a coarse turn command.

## Interface
- WINDOW, 1024, counting window length in enabled clock cycles (≥2)
- CNT_W, 10, spike counter width; counters saturate at 2^CNT_W−1
- PWM_W, 8, PWM counter and duty width
- BASE_DUTY, 128, straight-ahead duty for both motors
- SHIFT, 2, rate-to-duty gain as a left shift
- DEADBAND, 2, rate difference below which turn_cmd reports straight
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- en  input  1  global enable, shared with the network
- spike_in  input  2  spike vector from the network; [0] = Left, [1] = Right
- duty_l  output  PWM_W  current left shadow duty
- duty_r  output  PWM_W  current right shadow duty
- pwm_l  output  1  left motor PWM
- pwm_r  output  1  right motor PWM
- turn_cmd  output  2  00 straight, 01 left, 10 right; 11 never produced
- window_done  output  1  one-cycle pulse when duty_l, duty_r and turn_cmd update

## Operation
- **Reset (rst low, async):** clears every register.
  - All outputs are 0, the active duties are 0 (motors stopped), and the FSM goes to COUNT.
- **FSM states:** COUNT → CALC → COUNT.
  - Spike counting continues in every state; CALC only uses the latched rates.
- **Window counter:** wcnt runs 0..WINDOW−1 and advances only when en=1.
  - End-of-window (EOW) is en=1 with wcnt=WINDOW−1. On EOW, wcnt wraps to 0.
- **Spike counters:** cnt_l and cnt_r increment on en=1 when their spike bit is 1, and saturate at 2^CNT_W−1.
  - On EOW, rate_l/rate_r ← saturating(cnt + spike of that cycle), so a spike in the last window cycle counts in the closing window.
  - The counters then restart at 0; the next window starts empty.
- **CALC (one cycle after EOW):**
  - d = (rate_r − rate_l) << SHIFT, signed, width CNT_W+SHIFT+2.
  - duty_l ← clamp(BASE_DUTY + d, 0, 2^PWM_W−1).
  - duty_r ← clamp(BASE_DUTY − d, 0, 2^PWM_W−1).
  - turn_cmd ← 01 if rate_l − rate_r ≥ DEADBAND, 10 if rate_r − rate_l ≥ DEADBAND, else 00.
  - window_done ← 1 for exactly one cycle; return to COUNT.
- **PWM:**
  - pcnt is free-running 0..2^PWM_W−1 while en=1.
  - pwm_x = en & (pcnt < act_x), registered.
  - act_x loads from duty_x only on the cycle where pcnt = 2^PWM_W−1, so duty changes never take effect mid-period.
  - If the duty_x write and the period-end cycle coincide, act_x takes the newly written value.
- **en=0:** wcnt, counters, pcnt and the FSM hold; pwm_l/pwm_r are driven 0; spikes are ignored.
  - duty_l, duty_r and turn_cmd hold their values.

## Timing
- EOW at cycle E: rate registers valid at E+1 (CALC).
  - duty_l, duty_r, turn_cmd and the window_done pulse are visible at E+2.
- New duty reaches pwm_x in the first PWM period starting after the next pcnt = 2^PWM_W−1 cycle at or after E+1.
- pwm_x has 1-cycle register latency relative to pcnt.
  - Duty 0 gives a constant low output; duty 2^PWM_W−1 gives high for 2^PWM_W−1 of 2^PWM_W cycles.
- window_done is never asserted on two consecutive cycles; consecutive pulses are WINDOW enabled cycles apart.
- Asserting rst mid-window or mid-CALC aborts immediately: no window_done, and all outputs go to 0 asynchronously.

## Test plan
- **Reset values:** assert rst low for 3 cycles with random spikes → all outputs 0.
  - After release with no spikes, first window_done at enabled cycle 1025: duty_l = duty_r = 128, turn_cmd = 00.
- **Left-heavy window:** 10 Left spikes, 0 Right → duty_l = 88, duty_r = 168, turn_cmd = 01, window_done once.
  - pwm_l is then high 88 of every 256 cycles from the next period boundary.
- **Saturation and clamp:** spike_in[0] = 1 for the whole window, [1] = 0 → rate_l = 1023, duty_l = 0, duty_r = 255, turn_cmd = 01.
  - pwm_l is stuck low; pwm_r is high 255/256.
- **Boundary spike:** Right spike only at wcnt = WINDOW−1 → that window gives rate_r = 1, turn_cmd = 00 (below deadband), duty_l = 132, duty_r = 124.
  - The following spike-free window gives 128/128.
- **Glitch-free update:** window_done while pcnt = 40, with duty moving 128 → 88 → current period still shows 128 high cycles; the next period shows 88.
  - Repeat with the write coinciding with pcnt = 255: the next period shows 88.
- **en gating and async reset:** drop en for 50 cycles mid-window with spikes applied → the counts are unchanged, the window is lengthened by 50, and the PWM outputs are 0.
  - Then pull rst low mid-window → outputs 0 with no clock edge.
